// File: rtl/model_arbiter_if.sv
// Bundle of request, shared-model and response signals around model_arbiter.
// slave: the arbiter side. master: whoever drives requests and model results.
interface model_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:-2] req0_i0;
  logic [2:-2] req1_i0;
  logic [-2:2] req0_i1;
  logic [-2:2] req1_i1;
  logic [2:-2] m_i0;
  logic [-2:2] m_i1;
  logic        m_busy;
  logic [2:-2] m_o0;
  logic [-2:2] m_o1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [2:-2] rsp_o0;
  logic [-2:2] rsp_o1;

  modport slave (
    input  req_valid, req0_i0, req1_i0, req0_i1, req1_i1, m_o0, m_o1, rsp_ready,
    output req_ready, m_i0, m_i1, m_busy, rsp_valid, rsp_id, rsp_o0, rsp_o1
  );

  modport master (
    output req_valid, req0_i0, req1_i0, req0_i1, req1_i1, m_o0, m_o1, rsp_ready,
    input  req_ready, m_i0, m_i1, m_busy, rsp_valid, rsp_id, rsp_o0, rsp_o1
  );
endinterface

// File: rtl/model_arbiter.sv
// Two-requester front end for one shared model with a fixed latency of LAT
// cycles (1..15). One transaction in flight: accept, LAT cycles driving the
// model, then hold the response until it is taken.
// Build option MODEL_ARBITER_FIXED_PRIORITY_EN: requester 0 wins every tie and
// the round-robin last-grant register is not built.
//
// state | meaning
// IDLE  | offering req_ready to the arbitration winner
// WAIT  | latched operands on the model, counting down LAT cycles
// RESP  | response held on rsp_* until rsp_ready
module model_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  model_arbiter_if.slave arb_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        id_q;
  logic        m_busy_q;
  logic        rsp_valid_q;
  logic [2:-2] m_i0_q;
  logic [-2:2] m_i1_q;
  logic [2:-2] rsp_o0_q;
  logic [-2:2] rsp_o1_q;
  logic [1:0]  grant_d;
  logic        accept_id_d;
`ifdef MODEL_ARBITER_FIXED_PRIORITY_EN
`else
  // Id of the most recent grantee; reset to 1 so requester 0 wins the first tie.
  logic        last_q;
`endif

  // Choose the grantee while idle; nothing is offered in WAIT or RESP.
  always_comb begin
    grant_d = 2'b00;
    if (state_q == IDLE) begin
      case (arb_if.req_valid)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
`ifdef MODEL_ARBITER_FIXED_PRIORITY_EN
        2'b11:   grant_d = 2'b01;
`else
        2'b11:   grant_d = last_q ? 2'b01 : 2'b10;
`endif
        default: grant_d = 2'b00;
      endcase
    end
  end

  assign accept_id_d = grant_d[1];

  // Sequencer: accept, drive the model for LAT cycles, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      id_q        <= 1'b0;
      m_busy_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      m_i0_q      <= 5'h00;
      m_i1_q      <= 5'h00;
      rsp_o0_q    <= 5'h00;
      rsp_o1_q    <= 5'h00;
`ifdef MODEL_ARBITER_FIXED_PRIORITY_EN
`else
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant_d) begin
            state_q  <= WAIT;
            cnt_q    <= LAT_CNT;
            id_q     <= accept_id_d;
            m_busy_q <= 1'b1;
            m_i0_q   <= accept_id_d ? arb_if.req1_i0 : arb_if.req0_i0;
            m_i1_q   <= accept_id_d ? arb_if.req1_i1 : arb_if.req0_i1;
`ifdef MODEL_ARBITER_FIXED_PRIORITY_EN
`else
            last_q   <= accept_id_d;
`endif
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Model outputs are valid on the final counted cycle.
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_o0_q    <= arb_if.m_o0;
            rsp_o1_q    <= arb_if.m_o1;
            rsp_valid_q <= 1'b1;
            m_busy_q    <= 1'b0;
            m_i0_q      <= 5'h00;
            m_i1_q      <= 5'h00;
          end
        end
        RESP: begin
          if (arb_if.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_if.req_ready = grant_d;
  assign arb_if.m_i0      = m_i0_q;
  assign arb_if.m_i1      = m_i1_q;
  assign arb_if.m_busy    = m_busy_q;
  assign arb_if.rsp_valid = rsp_valid_q;
  assign arb_if.rsp_id    = id_q;
  assign arb_if.rsp_o0    = rsp_o0_q;
  assign arb_if.rsp_o1    = rsp_o1_q;

endmodule
